clk_div_prog: RTL and testbench

//  Runtime-programmable integer clock divider, divide-by-N for any N >= 2 (odd or even), exact 50% duty.
//  Odd N uses a posedge phase flop ANDed with a negedge copy.

---
 rtl/clk_div_prog.sv | 128 ++++++++++++
 tb/tb_clk_div_prog.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: divide-by-N (N >= 2), 50% duty for odd and even N.
// Divisor changes and en start/stop only take effect at out_clk period boundaries.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             out_clk,
  output logic             period_tick,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             cfg_err,
  output logic             running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_div, w_div_nxt;
  logic [WIDTH-1:0] r_pval, w_pval_nxt;
  logic             r_pv, w_pv_nxt;
  logic             r_p, w_p_nxt;
  logic             r_n;
  logic             r_cfg_err;

  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH:0]   w_half;
  logic             w_last;
  logic             w_legal;

  always_comb begin
    w_cnt_inc = r_cnt + WIDTH'(1);
    w_half    = ({1'b0, r_div} + (WIDTH+1)'(1)) >> 1;
    w_last    = (r_cnt == r_div - WIDTH'(1));
    w_legal   = div_load && (div_val >= WIDTH'(2));

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_p_nxt     = r_p;
    w_div_nxt   = r_div;
    w_pv_nxt    = r_pv;
    w_pval_nxt  = r_pval;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_p_nxt   = 1'b0;
        if (w_legal) w_div_nxt = div_val;
        if (en) begin
          w_state_nxt = S_RUN;
          w_p_nxt     = 1'b1;
        end
      end
      S_RUN, S_STOP: begin
        if (w_last) begin
          // Boundary: the next period (cnt=0 onward) runs with the pending divisor.
          w_cnt_nxt = '0;
          w_p_nxt   = 1'b1;
          if (r_pv) begin
            w_div_nxt = r_pval;
            w_pv_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_p_nxt   = ({1'b0, w_cnt_inc} < w_half);
        end

        if (r_state == S_RUN) begin
          if (!en) w_state_nxt = S_STOP;
        end else if (en) begin
          w_state_nxt = S_RUN;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_p_nxt     = 1'b0;
        end

        // A load arriving on the boundary cycle stays pending for the following boundary.
        if (w_legal) begin
          w_pv_nxt   = 1'b1;
          w_pval_nxt = div_val;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_p_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_p       <= 1'b0;
      r_div     <= WIDTH'(DEFAULT_DIV);
      r_pv      <= 1'b0;
      r_pval    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p       <= w_p_nxt;
      r_div     <= w_div_nxt;
      r_pv      <= w_pv_nxt;
      r_pval    <= w_pval_nxt;
      r_cfg_err <= div_load && (div_val < WIDTH'(2));
    end
  end

  // Half-cycle delayed phase; ANDing it in stretches the low time by half a clk for odd N.
  always_ff @(negedge clk) begin
    r_n <= r_p;
  end

  assign out_clk     = r_div[0] ? (r_p & r_n) : r_p;
  assign running     = (r_state != S_IDLE);
  assign period_tick = running && (r_cnt == '0);
  assign div_active  = r_div;
  assign pending     = r_pv;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: hand-computed vector table followed by
// model-scored directed sequences and a randomized stretch.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div_val = '0;
  logic       div_load = 1'b0;
  logic       out_clk, period_tick, pending, cfg_err, running;
  logic [7:0] div_active;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .out_clk(out_clk), .period_tick(period_tick), .div_active(div_active),
    .pending(pending), .cfg_err(cfg_err), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, load;
    logic [7:0] dval;
    logic       out, tick, run;
    logic [7:0] div;
    logic       pend, err;
  } vec_t;

  typedef struct {
    logic       out, tick, run;
    logic [7:0] div;
    logic       pend, err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit chk_neg = 0;

  // Reference model: 0=idle 1=run 2=stop
  int m_state = 0, m_cnt = 0, m_div = 3, m_pval = 0;
  bit m_p = 0, m_pv = 0, m_err = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model_step(input bit r, input bit e, input bit ld, input int dv);
    exp_t x;
    bit p_old = m_p;
    bit last;
    if (r) begin
      m_state = 0; m_cnt = 0; m_p = 0; m_div = 3; m_pv = 0; m_pval = 0; m_err = 0;
    end else begin
      m_err = ld && (dv < 2);
      if (m_state == 0) begin
        if (ld && dv >= 2) m_div = dv;
        if (e) begin m_state = 1; m_cnt = 0; m_p = 1; end
      end else begin
        last = (m_cnt == m_div - 1);
        if (last) begin
          if (m_pv) begin m_div = m_pval; m_pv = 0; end
          m_cnt = 0;
          m_p = 1;
        end else begin
          m_cnt++;
          m_p = (2 * m_cnt < m_div);  // cnt < ceil(N/2)
        end
        if (m_state == 1 && !e) m_state = 2;
        else if (m_state == 2 && e) m_state = 1;
        else if (m_state == 2 && last) begin m_state = 0; m_p = 0; end
        if (ld && dv >= 2) begin m_pv = 1; m_pval = dv; end
      end
    end
    x.run  = (m_state != 0);
    x.tick = x.run && (m_cnt == 0);
    x.div  = 8'(m_div);
    x.pend = m_pv;
    x.err  = m_err;
    x.out  = (m_div % 2 == 1) ? (m_p & p_old) : m_p;
    return x;
  endfunction

  // One clk cycle: drive after negedge, push expectation, compare after posedge.
  task automatic cycle(input bit r, input bit e, input bit ld, input int dv,
                       input bit use_tab, input exp_t tab_exp);
    exp_t x, got;
    @(negedge clk);
    #1;
    if (chk_neg) chk("out_clk_neg", out_clk, m_p);
    rst = r; en = e; div_load = ld; div_val = 8'(dv);
    x = model_step(r, e, ld, dv);
    sb.push_back(use_tab ? tab_exp : x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      chk("out_clk", out_clk, got.out);
      chk("period_tick", period_tick, got.tick);
      chk("running", running, got.run);
      chk("div_active", div_active, got.div);
      chk("pending", pending, got.pend);
      chk("cfg_err", cfg_err, got.err);
    end
    chk_neg = 1;
  endtask

  task automatic mcycle(input bit r, input bit e, input bit ld, input int dv);
    exp_t dummy;
    dummy = '{default: '0};
    cycle(r, e, ld, dv, 1'b0, dummy);
  endtask

  vec_t tab[$];
  exp_t te;

  initial begin
    // rst en ld dval | out tick run div pend err
    tab = '{
      '{1,0,0,0, 0,0,0,3,0,0},
      '{1,0,0,0, 0,0,0,3,0,0},
      '{1,0,0,0, 0,0,0,3,0,0},
      '{0,0,1,1, 0,0,0,3,0,1},
      '{0,0,1,0, 0,0,0,3,0,1},
      '{0,0,0,0, 0,0,0,3,0,0},
      '{0,0,1,4, 0,0,0,4,0,0},
      '{0,1,0,0, 1,1,1,4,0,0},
      '{0,1,0,0, 1,0,1,4,0,0},
      '{0,1,0,0, 0,0,1,4,0,0},
      '{0,1,0,0, 0,0,1,4,0,0},
      '{0,1,0,0, 1,1,1,4,0,0},
      '{0,0,0,0, 1,0,1,4,0,0},
      '{0,0,0,0, 0,0,1,4,0,0},
      '{0,0,0,0, 0,0,1,4,0,0},
      '{0,0,0,0, 0,0,0,4,0,0},
      '{0,0,0,0, 0,0,0,4,0,0}
    };
    foreach (tab[i]) begin
      te = '{tab[i].out, tab[i].tick, tab[i].run, tab[i].div, tab[i].pend, tab[i].err};
      cycle(tab[i].rst, tab[i].en, tab[i].load, int'(tab[i].dval), 1'b1, te);
    end

    // Default N=3 running
    repeat (2) mcycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) mcycle(0, 1, 0, 0);

    // Load 5 mid-period while N=3 runs
    for (int i = 0; i < 6 && m_cnt != 1; i++) mcycle(0, 1, 0, 0);
    chk("align_cnt1", m_cnt, 1);
    mcycle(0, 1, 1, 5);
    for (int i = 0; i < 12; i++) mcycle(0, 1, 0, 0);

    // Illegal loads while running, then a double load (last wins)
    mcycle(0, 1, 1, 1);
    mcycle(0, 1, 0, 0);
    mcycle(0, 1, 1, 0);
    mcycle(0, 1, 1, 2);
    mcycle(0, 1, 1, 6);
    for (int i = 0; i < 14; i++) mcycle(0, 1, 0, 0);

    // N=5: drop en at cnt=1, period completes then idle
    mcycle(0, 1, 1, 5);
    for (int i = 0; i < 14 && !(m_div == 5 && m_cnt == 1); i++) mcycle(0, 1, 0, 0);
    chk("align_n5_cnt1", m_cnt, 1);
    for (int i = 0; i < 8; i++) mcycle(0, 0, 0, 0);

    // Reset during the high phase
    mcycle(0, 1, 0, 0);
    mcycle(0, 1, 0, 0);
    mcycle(1, 1, 0, 0);
    mcycle(0, 0, 0, 0);
    mcycle(0, 1, 0, 0);

    // Randomized stretch
    for (int i = 0; i < 400; i++)
      mcycle(($urandom % 150) == 0, ($urandom % 8) != 0,
             ($urandom % 6) == 0, int'($urandom_range(0, 9)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
